// File: rtl/song_reader_if.sv
// Control, ROM and chord-player signals between the song sequencer and its surroundings.
// slave = song_reader side, master = the driving environment.
interface song_reader_if #(
  parameter int SONG_LEN_BITS = 5
);
  logic                     play;
  logic [1:0]               song;
  logic                     beat;
  logic [SONG_LEN_BITS+1:0] rom_addr;
  logic [15:0]              rom_data;
  logic [5:0]               note_to_load;
  logic [5:0]               duration;
  logic                     load_new_note;
  logic                     activate;
  logic                     song_done;

  modport slave (
    input  play, song, beat, rom_data,
    output rom_addr, note_to_load, duration, load_new_note, activate, song_done
  );

  modport master (
    output play, song, beat, rom_data,
    input  rom_addr, note_to_load, duration, load_new_note, activate, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Song sequencer: walks the ROM entries of the selected song, issues note/advance
// loads to the chord player and waits out advance events on beat ticks.
module song_reader #(
  parameter int SONG_LEN_BITS = 5
) (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, DONE} state_t;

  state_t                   state_q;
  logic [1:0]               song_q;
  logic [SONG_LEN_BITS-1:0] idx_q;
  logic [5:0]               wait_q;

  logic       is_adv;
  logic [5:0] f_note;
  logic [5:0] f_dur;
  logic       active_st;
  logic       song_changed;
  logic       run;
  logic       decode_load;
  logic       step_d;
  logic       unused_rom_bits;

  assign is_adv          = bus.rom_data[15];
  assign f_note          = bus.rom_data[14:9];
  assign f_dur           = bus.rom_data[8:3];
  assign unused_rom_bits = ^bus.rom_data[2:0];

  assign active_st    = (state_q == FETCH) || (state_q == DECODE) || (state_q == WAIT);
  assign song_changed = active_st && (bus.song != song_q);
  assign run          = bus.play && !song_changed;

  // ROM data only becomes valid during DECODE, so the load fields are decoded
  // from the registered state and the ROM word rather than registered again.
  assign decode_load = reset && (state_q == DECODE) && run;

  always_comb begin
    step_d = 1'b0;
    if (run) begin
      if (state_q == DECODE)
        step_d = !(is_adv && (f_dur != 6'd0));
      else if (state_q == WAIT)
        step_d = bus.beat && (wait_q == 6'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      song_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (bus.play) begin
            song_q  <= bus.song;
            state_q <= FETCH;
          end
        end
        FETCH, DECODE, WAIT: begin
          if (song_changed) begin
            song_q  <= bus.song;
            idx_q   <= '0;
            wait_q  <= '0;
            state_q <= FETCH;
          end else if (bus.play) begin
            if (step_d) begin
              if (&idx_q) begin
                state_q <= DONE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= FETCH;
              end
              if (state_q == WAIT)
                wait_q <= wait_q - 6'd1;
            end else if (state_q == FETCH) begin
              state_q <= DECODE;
            end else if (state_q == DECODE) begin
              wait_q  <= f_dur;
              state_q <= WAIT;
            end else if (bus.beat) begin
              wait_q <= wait_q - 6'd1;
            end
          end
        end
        DONE: begin
          if (!bus.play) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr      = reset ? {song_q, idx_q} : '0;
  assign bus.load_new_note = decode_load;
  assign bus.note_to_load  = (decode_load && !is_adv) ? f_note : 6'd0;
  assign bus.duration      = decode_load ? f_dur : 6'd0;
  assign bus.activate      = decode_load && is_adv;
  assign bus.song_done     = reset && (state_q == DONE);
endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a ROM model, a queue of expected load events
// decoded from ROM words, and per-cycle checking of the chord-player outputs.
module tb_song_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_reader_if #(.SONG_LEN_BITS(5)) bus();
  song_reader #(.SONG_LEN_BITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] rom_mem [0:127];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  typedef struct packed {
    logic [5:0] note;
    logic [5:0] dur;
    logic       act;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] note_w(input int n, input int d);
    return {1'b0, 6'(n), 6'(d), 3'b101};
  endfunction

  function automatic logic [15:0] adv_w(input int d);
    return {1'b1, 6'h2A, 6'(d), 3'b011};
  endfunction

  // What the chord player must receive for one ROM word.
  function automatic ev_t model(input logic [15:0] w);
    ev_t e;
    e.dur  = w[8:3];
    e.act  = w[15];
    e.note = w[15] ? 6'd0 : w[14:9];
    return e;
  endfunction

  task automatic push_entry(input int s, input int i);
    exp_q.push_back(model(rom_mem[s*32 + i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_pulse();
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
  endtask

  task automatic wait_addr(input logic [6:0] a, input int budget);
    int n;
    n = 0;
    while (bus.rom_addr !== a && n < budget) begin
      tick();
      n++;
    end
    chk("wait_addr", 32'(bus.rom_addr), 32'(a));
  endtask

  // Every cycle: a load must match the next expected event, otherwise fields are zero.
  always @(negedge clk) begin
    ev_t e;
    if (checking) begin
      if (bus.load_new_note === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'(bus.load_new_note), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("load_fields", 32'({bus.note_to_load, bus.duration, bus.activate}), 32'(e));
        end
      end else begin
        chk("idle_fields", 32'({bus.note_to_load, bus.duration, bus.activate}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int last;
    reset    = 1'b0;
    bus.play = 1'b0;
    bus.song = 2'd0;
    bus.beat = 1'b0;
    for (int i = 0; i < 128; i++) rom_mem[i] = note_w((i + 1) & 63, (i * 3) & 63);
    rom_mem[32] = note_w(20, 12);
    rom_mem[33] = note_w(24, 12);
    rom_mem[34] = adv_w(3);
    rom_mem[35] = adv_w(4);
    rom_mem[36] = adv_w(0);
    rom_mem[37] = note_w(30, 7);
    rom_mem[5]  = adv_w(6);
    rom_mem[64] = note_w(9, 1);
    rom_mem[65] = note_w(11, 2);
    rom_mem[103] = note_w(33, 0);

    repeat (3) tick();
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_load", 32'(bus.load_new_note), 32'd0);
    chk("rst_done", 32'(bus.song_done), 32'd0);
    chk("rst_fields", 32'({bus.note_to_load, bus.duration, bus.activate}), 32'd0);
    checking = 1'b1;
    reset = 1'b1;
    tick();
    chk("idle_addr", 32'(bus.rom_addr), 32'd0);

    // Basic note issue on song 1
    for (int i = 0; i < 4; i++) push_entry(1, i);
    bus.song = 2'd1;
    bus.play = 1'b1;
    tick();
    chk("s1_fetch0_addr", 32'(bus.rom_addr), 32'h20);
    chk("s1_fetch0_load", 32'(bus.load_new_note), 32'd0);
    tick();
    chk("s1_load0", 32'({bus.load_new_note, bus.note_to_load, bus.duration, bus.activate}),
        32'({1'b1, 6'd20, 6'd12, 1'b0}));
    tick();
    chk("s1_fetch1_addr", 32'(bus.rom_addr), 32'h21);
    tick();
    chk("s1_load1", 32'({bus.load_new_note, bus.note_to_load, bus.duration, bus.activate}),
        32'({1'b1, 6'd24, 6'd12, 1'b0}));
    tick();
    chk("s1_fetch2_addr", 32'(bus.rom_addr), 32'h22);
    tick();
    chk("s1_load2", 32'({bus.load_new_note, bus.note_to_load, bus.duration, bus.activate}),
        32'({1'b1, 6'd0, 6'd3, 1'b1}));
    tick();
    chk("s1_wait_load", 32'(bus.load_new_note), 32'd0);
    for (int b = 1; b <= 3; b++) begin
      beat_pulse();
      chk("s1_beat_addr", 32'(bus.rom_addr), (b < 3) ? 32'h22 : 32'h23);
      if (b < 3) tick();
    end

    // Pause during a 4-beat advance
    tick();
    chk("s2_load3", 32'({bus.load_new_note, bus.note_to_load, bus.duration, bus.activate}),
        32'({1'b1, 6'd0, 6'd4, 1'b1}));
    tick();
    repeat (2) begin
      beat_pulse();
      tick();
    end
    bus.play = 1'b0;
    repeat (5) begin
      beat_pulse();
      tick();
    end
    chk("s2_pause_addr", 32'(bus.rom_addr), 32'h23);
    bus.play = 1'b1;
    tick();
    push_entry(1, 4);
    beat_pulse();
    chk("s2_resume_beat1", 32'(bus.rom_addr), 32'h23);
    beat_pulse();
    chk("s2_resume_done", 32'(bus.rom_addr), 32'h24);

    // Zero-length advance
    tick();
    chk("s3_zero_adv", 32'({bus.load_new_note, bus.note_to_load, bus.duration, bus.activate}),
        32'({1'b1, 6'd0, 6'd0, 1'b1}));
    tick();
    chk("s3_no_wait_addr", 32'(bus.rom_addr), 32'h25);

    // Reset for one cycle while in DECODE
    tick();
    reset = 1'b0;
    #1;
    chk("s4_rst_load", 32'(bus.load_new_note), 32'd0);
    chk("s4_rst_outputs", 32'({bus.rom_addr, bus.note_to_load, bus.duration, bus.activate, bus.song_done}), 32'd0);
    tick();
    reset = 1'b1;
    push_entry(1, 0);
    tick();
    chk("s4_refetch_addr", 32'(bus.rom_addr), 32'h20);
    tick();
    chk("s4_refetch_load", 32'({bus.load_new_note, bus.note_to_load, bus.duration}),
        32'({1'b1, 6'd20, 6'd12}));
    tick();
    bus.play = 1'b0;
    chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;

    // Song change while waiting, then while in DECODE
    bus.song = 2'd0;
    for (int i = 0; i < 6; i++) push_entry(0, i);
    bus.play = 1'b1;
    wait_addr(7'h05, 40);
    tick();
    tick();
    beat_pulse();
    tick();
    beat_pulse();
    bus.song = 2'd2;
    #1;
    chk("s5_chg_cycle_load", 32'(bus.load_new_note), 32'd0);
    tick();
    chk("s5_chg_addr", 32'(bus.rom_addr), 32'h40);
    chk("s5_chg_fetch_load", 32'(bus.load_new_note), 32'd0);
    push_entry(2, 0);
    tick();
    chk("s5_song2_load", 32'({bus.load_new_note, bus.note_to_load, bus.duration}),
        32'({1'b1, 6'd9, 6'd1}));
    tick();
    tick();
    bus.song = 2'd3;
    #1;
    chk("s5_chg_in_decode_load", 32'(bus.load_new_note), 32'd0);
    push_entry(3, 0);
    tick();
    chk("s5_song3_addr", 32'(bus.rom_addr), 32'h60);
    tick();
    tick();
    bus.play = 1'b0;
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;

    // Whole song of notes through to DONE
    for (int i = 0; i < 32; i++) push_entry(3, i);
    bus.play = 1'b1;
    n = 0;
    last = 0;
    for (int k = 0; k < 120 && n < 32; k++) begin
      tick();
      if (bus.load_new_note === 1'b1) begin
        n++;
        if (n > 1) chk("s6_load_spacing", 32'(k - last), 32'd2);
        last = k;
      end
    end
    chk("s6_load_count", 32'(n), 32'd32);
    tick();
    chk("s6_done_set", 32'(bus.song_done), 32'd1);
    repeat (6) tick();
    chk("s6_done_held", 32'(bus.song_done), 32'd1);
    chk("s6_queue_empty", 32'(exp_q.size()), 32'd0);
    bus.play = 1'b0;
    tick();
    chk("s6_done_clear", 32'(bus.song_done), 32'd0);
    chk("s6_idle_addr", 32'(bus.rom_addr), 32'h60);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter SONG_LEN_BITS, default 5, meaning log2 of entries per song (32 entries).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 play  input  1  high = sequence song; low = pause.
REQ-005 song  input  2  song select.
REQ-006 beat  input  1  1/48 s tick, one clk cycle wide.
REQ-007 rom_addr  output  2+SONG_LEN_BITS  {song_latched, entry_idx}.
REQ-008 rom_data  input  16  ROM word, valid one cycle after rom_addr changes.
REQ-009 note_to_load  output  6  note number to the chord player.
REQ-010 duration  output  6  note duration or advance length, in beats.
REQ-011 load_new_note  output  1  one-cycle load strobe to the chord player.
REQ-012 activate  output  1  high with load_new_note marks an advance (timing) event.
REQ-013 song_done  output  1  high from the end of song until play goes low.

Function
REQ-014 The ROM word format SHALL be as follows.
- bit15: 0 = note event, 1 = advance event.
- [14:9]: note.
- [8:3]: duration.
- [2:0]: ignored.
REQ-015 The block SHALL use the states IDLE, FETCH, DECODE, WAIT, DONE.
REQ-016 IDLE: entry_idx=0; when play=1, latch song, go to FETCH.
REQ-017 FETCH: drive rom_addr for one cycle, then go to DECODE.
REQ-018 DECODE with play=1: assert load_new_note for exactly this cycle and drive the fields.
- Note event: note_to_load=[14:9], duration=[8:3], activate=0.
- Advance event: note_to_load=0, duration=[8:3], activate=1.
REQ-019 After DECODE, an advance event with duration>0 SHALL load wait_cnt=duration and go to WAIT.
REQ-020 After DECODE, any other event SHALL take the index-advance step.
REQ-021 WAIT: on beat&&play, decrement wait_cnt; on the cycle wait_cnt goes 1->0, take the index-advance step.
REQ-022 Index-advance step: if entry_idx is all-ones, go to DONE; else entry_idx+1 and go to FETCH.
REQ-023 DONE: song_done=1, no loads; when play=0, go to IDLE and clear entry_idx.
REQ-024 Pause: with play=0 in FETCH/DECODE/WAIT, the state machine SHALL hold its state.
- No load_new_note is issued.
- beat is ignored.
- wait_cnt is held.
- On resume, behaviour continues exactly where it stopped.
REQ-025 Song change: if song differs from song_latched in FETCH/DECODE/WAIT, the block SHALL act on the next cycle as follows.
- Latch the new song, set entry_idx=0, abort the wait, go to FETCH.
- No load_new_note is issued in the cycle the change is detected.
REQ-026 The change check SHALL take priority over pause and over the beat decrement.
REQ-027 Outside DECODE (or in DECODE with play=0), note_to_load, duration and activate SHALL be 0.
REQ-028 A note event with duration=0 SHALL still be issued (single load pulse, duration=0).
REQ-029 Consecutive note events SHALL be issued every 2 cycles (FETCH, DECODE) with no beat dependence.
REQ-030 rom_addr SHALL be registered and stable from FETCH through the following DECODE.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL set state=IDLE, entry_idx=0, wait_cnt=0 and song_latched=0.
REQ-032 During reset: load_new_note=0, activate=0, note_to_load=0, duration=0, song_done=0, rom_addr=0.
REQ-033 Reset asserted mid-song SHALL abort any wait, issue no further loads, and restart from entry 0 when play=1 after reset releases.

Verification
REQ-034 Basic note issue: song=1, entries 0-1 are notes (note 20 dur 12, note 24 dur 12), entry 2 is advance dur 3.
- load pulses at FETCH+1 for each entry: (20,12,act=0), (24,12,act=0), (0,3,act=1).
- Then exactly 3 beats elapse before rom_addr=0x23 is presented.
REQ-035 Pause in WAIT: advance dur 4, play dropped after 2 beats, 5 beats sent while paused.
- wait_cnt holds at 2; no loads while paused.
- After play=1, 2 more beats finish the wait.
REQ-036 End of song: all 32 entries are notes.
- 32 load pulses, 2 cycles apart.
- song_done rises after entry 31; no further loads.
- song_done clears and the block returns to IDLE when play=0.
REQ-037 Song change mid-WAIT: song 0 at entry 5 waiting; song set to 2.
- Next cycle: FETCH, rom_addr=0x40.
- No load issued in the change cycle.
REQ-038 Reset mid-operation: reset=0 for 1 cycle during DECODE.
- load_new_note=0 in the reset cycle and all outputs 0.
- After release with play=1, entry 0 is refetched.
REQ-039 Zero-length advance: advance dur 0 produces one load pulse (0,0,act=1) and proceeds to FETCH with no beat wait.
